// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op encodings, EXE_CMD constants and state encoding for alu_wide_sequencer
package alu_seq_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_MVN = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_ORR = 3'd5,
    OP_EOR = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  localparam logic [CMD_W-1:0] CMD_NONE = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_MOV  = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MVN  = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_ADD  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADC  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SBC  = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND  = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ORR  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_EOR  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_wide_sequencer_if.sv
// rtl/alu_wide_sequencer_if.sv - request/response/ALU bundle; ALU_WIDE_SEQ_NARROW_EN adds req_narrow
interface alu_wide_sequencer_if;
  import alu_seq_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
`ifdef ALU_WIDE_SEQ_NARROW_EN
  logic             req_narrow;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_w;
  logic [3:0]       rsp_sr;
  logic             alu_sel;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [CMD_W-1:0] alu_cmd;
  logic             alu_c;
  logic [31:0]      alu_w;
  logic [3:0]       alu_sr;

  modport slave (
`ifdef ALU_WIDE_SEQ_NARROW_EN
    input  req_narrow,
`endif
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_w, alu_sr,
    output req_ready, rsp_valid, rsp_w, rsp_sr, alu_sel, alu_a, alu_b, alu_cmd, alu_c
  );

  modport master (
`ifdef ALU_WIDE_SEQ_NARROW_EN
    output req_narrow,
`endif
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_w, alu_sr,
    input  req_ready, rsp_valid, rsp_w, rsp_sr, alu_sel, alu_a, alu_b, alu_cmd, alu_c
  );

endinterface

// File: rtl/alu_seq_cmd_map.sv
// rtl/alu_seq_cmd_map.sv - maps latched op and pass select to the ALU EXE_CMD
module alu_seq_cmd_map
  import alu_seq_pkg::*;
(
  input  op_e              op_i,
  input  logic             hi_i,
  output logic [CMD_W-1:0] cmd_o
);

  // Only ADD/SUB change command on the high pass, to pick up the chained carry.
  always_comb begin
    cmd_o = CMD_NONE;
    case (op_i)
      OP_MOV:  cmd_o = CMD_MOV;
      OP_MVN:  cmd_o = CMD_MVN;
      OP_ADD:  cmd_o = hi_i ? CMD_ADC : CMD_ADD;
      OP_SUB:  cmd_o = hi_i ? CMD_SBC : CMD_SUB;
      OP_AND:  cmd_o = CMD_AND;
      OP_ORR:  cmd_o = CMD_ORR;
      OP_EOR:  cmd_o = CMD_EOR;
      default: cmd_o = CMD_NONE;
    endcase
  end

endmodule

// File: rtl/alu_wide_sequencer.sv
// rtl/alu_wide_sequencer.sv - runs 64-bit ops as two 32-bit ALU passes; ALU_WIDE_SEQ_NARROW_EN enables single-pass narrow ops
module alu_wide_sequencer
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_wide_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] w_q, w_d;
  logic [31:0] lo_q, lo_d;
  logic        cy_q, cy_d;
  logic [3:0]  sr_q, sr_d;
`ifdef ALU_WIDE_SEQ_NARROW_EN
  logic        narrow_q, narrow_d;
`endif

  logic             hi_pass;
  logic [CMD_W-1:0] map_cmd;
  logic             req_ready;
  logic             rsp_valid;
  logic             alu_sel;
  logic             alu_c;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;

  alu_seq_cmd_map u_cmd_map (
    .op_i  (op_q),
    .hi_i  (hi_pass),
    .cmd_o (map_cmd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MOV;
      a_q      <= '0;
      b_q      <= '0;
      w_q      <= '0;
      lo_q     <= '0;
      cy_q     <= 1'b0;
      sr_q     <= '0;
`ifdef ALU_WIDE_SEQ_NARROW_EN
      narrow_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      w_q      <= w_d;
      lo_q     <= lo_d;
      cy_q     <= cy_d;
      sr_q     <= sr_d;
`ifdef ALU_WIDE_SEQ_NARROW_EN
      narrow_q <= narrow_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    w_d       = w_q;
    lo_d      = lo_q;
    cy_d      = cy_q;
    sr_d      = sr_q;
`ifdef ALU_WIDE_SEQ_NARROW_EN
    narrow_d  = narrow_q;
`endif
    hi_pass   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_sel   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d     = op_e'(bus.req_op);
          a_d      = bus.req_a;
          b_d      = bus.req_b;
`ifdef ALU_WIDE_SEQ_NARROW_EN
          narrow_d = bus.req_narrow;
`endif
          state_d  = ST_LO;
        end
      end
      ST_LO: begin
        alu_sel = 1'b1;
        alu_a   = a_q[31:0];
        alu_b   = b_q[31:0];
        lo_d    = bus.alu_w;
        // Carry/borrow derived from operands; the ALU's C flag is sign-based and unusable here.
        case (op_q)
          OP_ADD:  cy_d = (bus.alu_w < a_q[31:0]);
          OP_SUB:  cy_d = (a_q[31:0] < b_q[31:0]);
          default: cy_d = 1'b0;
        endcase
        state_d = ST_HI;
`ifdef ALU_WIDE_SEQ_NARROW_EN
        if (narrow_q) begin
          w_d     = {32'h0, bus.alu_w};
          sr_d    = bus.alu_sr;
          state_d = ST_DONE;
        end
`endif
      end
      ST_HI: begin
        hi_pass = 1'b1;
        alu_sel = 1'b1;
        alu_a   = a_q[63:32];
        alu_b   = b_q[63:32];
        alu_c   = cy_q;
        w_d     = {bus.alu_w, lo_q};
        sr_d    = {bus.alu_sr[3], bus.alu_sr[2] & (lo_q == 32'h0), bus.alu_sr[1], bus.alu_sr[0]};
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_w     = w_q;
  assign bus.rsp_sr    = sr_q;
  assign bus.alu_sel   = alu_sel;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_cmd   = alu_sel ? map_cmd : CMD_NONE;
  assign bus.alu_c     = alu_c;

endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
- Multi-cycle controller that runs 64-bit operations on the 32-bit execute-stage ALU.
- Issues two ALU passes per request: a low word, then a high word. For ADD/SUB the high pass uses the carry-chained command (ADC/SBC) with the low-word carry computed internally.
- Requests arrive over a valid/ready handshake from the coprocessor/long-op path.
- Asserts alu_sel while it owns the shared ALU, so the execute-stage mux hands it the ALU operands.

Parameters:
- CMD_W, 4, width of the ALU EXE_CMD field. Must stay 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  operation: 0 MOV, 1 MVN, 2 ADD, 3 SUB, 4 AND, 5 ORR, 6 EOR; 7 reserved
- req_a  in  64  operand A
- req_b  in  64  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_w  out  64  result
- rsp_sr  out  4  flags {N,Z,C,V}
- alu_sel  out  1  sequencer owns the ALU this cycle
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_cmd  out  CMD_W  ALU EXE_CMD
- alu_c  out  1  ALU carry input
- alu_w  in  32  ALU result (combinational from alu_a/alu_b/alu_cmd/alu_c)
- alu_sr  in  4  ALU flags {N,Z,C,V}

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_w=0; rsp_sr=0; alu_sel=0; alu_a=0; alu_b=0; alu_cmd=0; alu_c=0. Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, a, b; go to LO.
  - Reserved op 7 is latched and executed with alu_cmd=0, giving W=0.
- LO:
  - alu_sel=1; alu_a=a[31:0]; alu_b=b[31:0].
  - alu_cmd: MOV 0001, MVN 1001, ADD 0010, SUB 0100, AND 0110, ORR 0111, EOR 1000.
  - alu_c=0.
  - Capture lo=alu_w. Capture cy:
    - ADD: cy=(alu_w < a[31:0]), unsigned compare.
    - SUB: cy=(a[31:0] < b[31:0]), i.e. the borrow.
    - Other ops: cy=0.
  - The ALU's own C flag is not used for chaining; it is sign-based.
  - Go to HI.
- HI:
  - alu_sel=1; alu_a=a[63:32]; alu_b=b[63:32].
  - alu_cmd: ADD becomes 0011 (ADC), SUB becomes 0101 (SBC); all other ops keep their LO command.
  - alu_c=cy.
  - Capture rsp_w={alu_w, lo}.
  - Capture rsp_sr: N=alu_sr[3]; Z=alu_sr[2] & (lo==0); C=alu_sr[1]; V=alu_sr[0].
  - Go to DONE.
- DONE:
  - rsp_valid=1, outputs stable.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: request accepted at edge T; rsp_valid is high after edge T+2. Throughput is at most one op per 4 cycles; a request is not accepted in the cycle rsp completes.
- alu_a, alu_b, alu_cmd, alu_c are driven combinationally from state and latched operands; they are 0 in IDLE and DONE.
- req_ready=0 in LO, HI and DONE. Inputs are ignored outside IDLE.
- Wrap-around: ADD 0xFFFFFFFF_FFFFFFFF + 1 gives W=0, Z=1.

Optional Feature:
- Macro ALU_WIDE_SEQ_NARROW_EN.
- With the macro: extra input port req_narrow (1 bit), latched on accept. When set, LO captures directly into rsp_w={32'h0, alu_w} and rsp_sr=alu_sr, then goes to DONE, skipping HI. Latency drops by one cycle.
- Without the macro: the port is absent and every op takes two passes.

Decomposition:
- Package alu_seq_pkg holds:
  - op encodings OP_MOV..OP_EOR;
  - EXE_CMD constants CMD_MOV=0001, CMD_MVN=1001, CMD_ADD=0010, CMD_ADC=0011, CMD_SUB=0100, CMD_SBC=0101, CMD_AND=0110, CMD_ORR=0111, CMD_EOR=1000;
  - state encoding.
- One natural sub-module, alu_seq_cmd_map: combinational op + pass-select to alu_cmd. Everything else stays in the top.

Test Plan:
- ADD a=0x00000000_FFFFFFFF, b=1 -> alu_cmd 0010 then 0011 with alu_c=1; rsp_w=0x00000001_00000000, Z=0; rsp_valid 2 edges after accept.
- SUB a=0x00000001_00000000, b=1 -> high pass 0101 with alu_c=1; rsp_w=0x00000000_FFFFFFFF, N=0, Z=0.
- SUB a=b=0x12345678_9ABCDEF0 -> rsp_w=0, Z=1, N=0.
- EOR a=0xFFFF0000_00FF00FF, b=0xFFFFFFFF_FFFFFFFF -> rsp_w=0x0000FFFF_FF00FF00, alu_c=0 on both passes, C=V=0.
- Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_w stable, req_ready=0; release -> IDLE next cycle, new request accepted.
- Assert rst during HI -> all outputs return to reset values immediately; the next request completes correctly with no stale lo/cy.
